// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
// Used by pipelined_adder and adder_slice; PIPELINED_ADDER_OVF_EN does not affect this file.
package adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    // Pipeline depth: one register stage per CHUNK-bit slice of the carry chain.
    function automatic int adder_stages(input int width, input int chunk);
        if (chunk < 1) begin
            return 1;
        end
        return width / chunk;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit slice of the carry chain: sum_o/cout_o = a_i + b_i + cin_i.
// Stage registers live in pipelined_adder; PIPELINED_ADDER_OVF_EN does not affect this file.
module adder_slice
    import adder_pkg::*;
#(
    parameter int W = DEF_CHUNK
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    // One bit wider than the operands; the top bit is the slice carry.
    logic [W:0] full;

    assign full   = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
    assign sum_o  = full[W-1:0];
    assign cout_o = full[W];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder, sum = a + b + cin, one register stage per CHUNK-bit slice.
// Define PIPELINED_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = adder_stages(WIDTH, CHUNK);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("pipelined_adder: CHUNK=%0d must be >= 1 and divide WIDTH=%0d", CHUNK, WIDTH);
    end

    // acc collects finished slices from the top down; op_a/op_b shift right as slices are consumed.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] acc;
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
`ifdef PIPELINED_ADDER_OVF_EN
        logic             a_msb;
        logic             b_msb;
`endif
    } adder_stage_t;

    adder_stage_t stage_in [STAGES];
    adder_stage_t stage_d  [STAGES];
    adder_stage_t stage_q  [STAGES];
    logic         adv;

    // Handshake: a transfer happens on an edge where valid && ready; the whole pipe advances
    // together whenever the output register is empty or being drained, so in_ready = adv.
    assign adv      = !stage_q[STAGES-1].valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        stage_in[0]       = '0;
        stage_in[0].valid = in_valid;
        stage_in[0].carry = cin;
        stage_in[0].op_a  = a;
        stage_in[0].op_b  = b;
`ifdef PIPELINED_ADDER_OVF_EN
        stage_in[0].a_msb = a[WIDTH-1];
        stage_in[0].b_msb = b[WIDTH-1];
`endif
        for (int k = 1; k < STAGES; k++) begin
            stage_in[k] = stage_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] slice_sum;
        logic             slice_cout;
        adder_stage_t     nxt;

        adder_slice #(
            .W      (CHUNK)
        ) u_slice (
            .a_i    (stage_in[k].op_a[CHUNK-1:0]),
            .b_i    (stage_in[k].op_b[CHUNK-1:0]),
            .cin_i  (stage_in[k].carry),
            .sum_o  (slice_sum),
            .cout_o (slice_cout)
        );

        always_comb begin
            nxt       = stage_in[k];
            nxt.carry = slice_cout;
            nxt.acc   = (stage_in[k].acc >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));
            nxt.op_a  = stage_in[k].op_a >> CHUNK;
            nxt.op_b  = stage_in[k].op_b >> CHUNK;
        end

        assign stage_d[k] = nxt;
    end

    // Bubbles only move the valid bit, so sum/cout keep their last value while out_valid=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k].valid <= stage_in[k].valid;
                if (stage_in[k].valid) begin
                    stage_q[k] <= stage_d[k];
                end
            end
        end
    end

    assign out_valid = stage_q[STAGES-1].valid;
    assign sum       = stage_q[STAGES-1].acc;
    assign cout      = stage_q[STAGES-1].carry;

`ifdef PIPELINED_ADDER_OVF_EN
    assign ovf = (stage_q[STAGES-1].a_msb == stage_q[STAGES-1].b_msb)
              && (stage_q[STAGES-1].acc[WIDTH-1] != stage_q[STAGES-1].a_msb);
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: 16/4 instance with a scoreboard, plus a single-stage 8/8 instance.
// Honours PIPELINED_ADDER_OVF_EN when defined.
module tb_pipelined_adder;

    localparam int W  = 16;
    localparam int W8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [W-1:0]  a, b, sum;
    logic          in_valid8, in_ready8, cin8, out_valid8, cout8;
    logic [W8-1:0] a8, b8, sum8;
`ifdef PIPELINED_ADDER_OVF_EN
    logic          ovf, ovf8;
`endif

    int checks = 0;
    int errors = 0;
    logic [W+1:0] exp_q[$];  // {ovf, cout, sum}
    bit rand_rdy = 1'b0;

    pipelined_adder #(.WIDTH(W), .CHUNK(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPELINED_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    pipelined_adder #(.WIDTH(W8), .CHUNK(W8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .out_ready (1'b1),
        .sum       (sum8),
        .cout      (cout8)
`ifdef PIPELINED_ADDER_OVF_EN
        ,
        .ovf       (ovf8)
`endif
    );

    task automatic check(input string name, input logic [W+1:0] got, input logic [W+1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    // Driver: presents one operand set and returns #1 after the accepting edge.
    task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        int waited = 0;
        @(negedge clk);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back({eo, ec, es});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
    endtask

    // Monitor: a result transfers on the coming edge when out_valid && out_ready.
    initial begin : monitor
        logic [W+1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got sum=%h cout=%b, required none", sum, cout);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", sum, e[W-1:0]);
                    check("cout", cout, e[W]);
`ifdef PIPELINED_ADDER_OVF_EN
                    check("ovf", ovf, e[W+1]);
`endif
                end
            end
        end
    end

    initial begin : rand_ready
        forever begin
            @(negedge clk);
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [W8-1:0] va8 [4] = '{8'hFF, 8'h7F, 8'h12, 8'h7F};
    logic [W8-1:0] vb8 [4] = '{8'h01, 8'h80, 8'h34, 8'h01};
    logic          vc8 [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [W8-1:0] es8 [4] = '{8'h00, 8'h00, 8'h46, 8'h80};
    logic          ec8 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic          eo8 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin : main
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid8", out_valid8, 0);
`ifdef PIPELINED_ADDER_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;

        // Single beat: out_valid rises after the 4th edge counting the accepting one.
        issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            check("latency_valid", out_valid, (i == 3));
        end
        drain();

        // Back-to-back: three results on consecutive cycles, then a bubble.
        issue(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
        issue(16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0);
        issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check("b2b_valid", out_valid, (i <= 3));
        end
        drain();

        // Backpressure: fill the pipe with out_ready low, hold 3 cycles, then release.
        @(negedge clk);
        out_ready = 1'b0;
        issue(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        issue(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        issue(16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_sum", sum, 16'h0003);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        // Reset mid-flight: two accepted operations are discarded.
        issue(16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("postrst_out_valid", out_valid, 0);
        end
        issue(16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0);
        drain();

        // Directed vectors under random downstream backpressure.
        rand_rdy = 1'b1;
        issue(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        issue(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        issue(16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1);
        issue(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        issue(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        drain();
        rand_rdy = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;

        // Single-stage instance: latency 1, one result per cycle.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a8 = va8[i]; b8 = vb8[i]; cin8 = vc8[i]; in_valid8 = 1'b1;
            #1;
            check("w8_in_ready", in_ready8, 1);
            @(posedge clk);
            #1;
            check("w8_valid", out_valid8, 1);
            check("w8_sum", sum8, es8[i]);
            check("w8_cout", cout8, ec8[i]);
`ifdef PIPELINED_ADDER_OVF_EN
            check("w8_ovf", ovf8, eo8[i]);
`endif
        end
        in_valid8 = 1'b0;
        @(posedge clk);
        #1;
        check("w8_idle", out_valid8, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
